// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank: frame geometry,
// R/W encoding, frame-phase states and the synchroniser depth floor.
package spi_reg_pkg;

    localparam int   SYNC_STAGES_MIN = 2;
    localparam logic RW_WRITE        = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_e;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser followed by one history flop for rise/fall detection.
// RST_VAL is the idle level of the input so no edge is seen at reset release.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank, fully oversampled in the clk domain: framed
// writes with per-register strobes, read-back on MISO, bad-length reporting.
//
// state | meaning
// IDLE  | deselected, or frame aborted; waiting for cs_n to fall
// ADDR  | shifting in the R/W bit and address
// DATA  | shifting data in; on reads, shifting register contents out
// DONE  | full frame received; extra edges only push the counter to saturation
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_sclk,
    input  logic                       spi_cs_n,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic                       spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int SYNC_N  = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_W + 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_i(spi_sclk),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // Same depth as sclk so the sampled bit lines up with the detected rise.
    spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .async_i(spi_mosi),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic                 rw_q, rw_d;
    logic                 miso_q, miso_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_stb_q, wr_stb_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        miso_d      = miso_q;
        regs_d      = regs_q;
        wr_stb_d    = '0;
        frame_err_d = 1'b0;
        cnt_inc     = cnt_q;
        if (cnt_q != CNT_SAT) begin
            cnt_inc = cnt_q + 1'b1;
        end

        if (cs_fall) begin
            state_d = ADDR;
            cnt_d   = '0;
            rx_d    = '0;
            miso_d  = 1'b0;
        end else if (cs_rise) begin
            // A complete frame holds R/W in the top bit and the address below it.
            if (state_q != IDLE) begin
                if (cnt_q == CNT_FRAME) begin
                    if (rx_q[FRAME_W-1] == RW_WRITE) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (rx_q[FRAME_W-2 -: ADDR_W] == ADDR_W'(i)) begin
                                regs_d[i]   = rx_q[DATA_W-1:0];
                                wr_stb_d[i] = 1'b1;
                            end
                        end
                    end
                end else if (cnt_q != '0) begin
                    frame_err_d = 1'b1;
                end
            end
            state_d = IDLE;
            miso_d  = 1'b0;
        end else if (!cs_lvl && state_q != IDLE) begin
            if (sclk_rise) begin
                rx_d  = {rx_q[FRAME_W-2:0], mosi_s};
                cnt_d = cnt_inc;
                if (state_q == ADDR && cnt_inc == CNT_ADDR_END) begin
                    rw_d  = rx_d[ADDR_W];
                    tx_d  = '0;
                    if (rx_d[ADDR_W] != RW_WRITE) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (rx_d[ADDR_W-1:0] == ADDR_W'(i)) begin
                                tx_d = regs_q[i];
                            end
                        end
                    end
                    state_d = DATA;
                end else if (state_q == DATA && cnt_inc == CNT_FRAME) begin
                    state_d = DONE;
                end
            end else if (sclk_fall) begin
                if (state_q == DATA && rw_q != RW_WRITE) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            miso_q      <= 1'b0;
            regs_q      <= '{default: '0};
            wr_stb_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            miso_q      <= miso_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs_lvl;
    assign wr_stb      = wr_stb_q;
    assign frame_err   = frame_err_q;

endmodule
